// File: rtl/unary_stream_decoder.sv
// unary_stream_decoder
// Counts the '1' bits of a unary (stochastic) bitstream over a window of
// N = 2**WIN_LOG2 valid samples. It returns the count as an unsigned magnitude
// (oData, 0..N) and as a bipolar signed value (oDataBip = 2*oData - N). Both
// are held in a valid/ready output register.
//
// Ports
//   iClk      clock, rising edge
//   iRst      synchronous active-high reset
//   iStart    arm the decoder, or re-align the current window
//   iEn       iBit carries a valid stream sample this cycle
//   iBit      unary stream bit
//   iReady    downstream accepts the output register
//   iClrOvr   clear the sticky overrun flag
//   oData     ones count of the last completed window
//   oDataBip  signed bipolar value of the last completed window
//   oValid    output register holds an unconsumed result
//   oBusy     a window is being accumulated
//   oOverrun  sticky flag: a completed window was dropped
module unary_stream_decoder #(
    parameter int WIN_LOG2 = 8,
    parameter bit CONT     = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic                  iEn,
    input  logic                  iBit,
    input  logic                  iReady,
    input  logic                  iClrOvr,
    output logic [WIN_LOG2:0]     oData,
    output logic [WIN_LOG2+1:0]   oDataBip,
    output logic                  oValid,
    output logic                  oBusy,
    output logic                  oOverrun
);

    localparam int N = 2 ** WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] LAST_SAMPLE = WIN_LOG2'(N - 1);
    localparam logic [WIN_LOG2+1:0] N_BIP       = (WIN_LOG2 + 2)'(N);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WIN_LOG2-1:0] sample_cnt;
    logic [WIN_LOG2:0]   ones_cnt;
    logic                window_end;
    logic [WIN_LOG2:0]   result;
    logic                load;
    logic                drop;

    // A restart in the same cycle wins over the sample, so a window cannot
    // end in a cycle with iStart. The final sample's bit is added on the fly.
    always_comb begin
        window_end = (state == ACCUM) && !iStart && iEn && (sample_cnt == LAST_SAMPLE);
        result     = ones_cnt + {{WIN_LOG2{1'b0}}, iBit};
        load       = window_end && (!oValid || iReady);
        drop       = window_end && oValid && !iReady;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (iStart) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (window_end && !CONT) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The sample counter stops at N-1 and clears on the window's last sample.
    // The ones counter therefore never exceeds N-1 here and cannot wrap.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (iStart || window_end) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if ((state == ACCUM) && iEn) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= result;
        end
    end

    // A new result may load when the register is empty, or when it is being
    // consumed in this same cycle. Otherwise the new result is dropped.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oData    <= '0;
            oDataBip <= '0;
            oValid   <= 1'b0;
        end else if (load) begin
            oData    <= result;
            oDataBip <= {result, 1'b0} - N_BIP;
            oValid   <= 1'b1;
        end else if (oValid && iReady) begin
            oValid   <= 1'b0;
        end
    end

    // A new overrun takes priority over a clear in the same cycle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oOverrun <= 1'b0;
        end else if (drop) begin
            oOverrun <= 1'b1;
        end else if (iClrOvr) begin
            oOverrun <= 1'b0;
        end
    end

    assign oBusy = (state == ACCUM);

endmodule
